// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle MULT/DIV sequencer.
//   MULDIV_WIDTH : operand / HI / LO width
//   OP_MULT/OP_DIV : encoding of the op input
//   state_t      : sequencer FSM states (explicit legacy encoding)
// Optional feature macro used by muldiv_seq: MULDIV_DIVZERO_TRAP_EN.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 16;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or
// restoring divide on the {acc_hi, acc_lo} working pair.
// Ports:
//   op      in   0=MULT, 1=DIV
//   acc_hi  in   upper working half (partial product / partial remainder)
//   acc_lo  in   lower working half (multiplier bits / dividend+quotient bits)
//   a       in   latched multiplicand / dividend
//   b       in   latched multiplier / divisor
//   nxt_hi  out  next acc_hi
//   nxt_lo  out  next acc_lo
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sh_hi;
    logic [WIDTH:0]   trial;

    always_comb begin
        sum    = '0;
        sh_hi  = '0;
        trial  = '0;
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        if (op == OP_MULT) begin
            sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a} : '0);
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            sh_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            // The bit shifted out of acc_hi is kept as the trial's MSB so
            // divisors above 2^(WIDTH-1) still restore correctly; the
            // partial remainder is below 2*b, so trial[WIDTH] is a clean
            // borrow flag.
            trial = {acc_hi[WIDTH-1], sh_hi} - {1'b0, b};
            if (trial[WIDTH] == 1'b0) begin
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = sh_hi;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned WIDTHxWIDTH multiply / WIDTH/WIDTH divide
// sequencer owning the architected HI/LO pair (MFHI/MFLO source).
// One iteration per clock; start/busy/done handshake to the control unit.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   launch op; accepted in IDLE or DONE, ignored in RUN
//   op         in   0=MULT, 1=DIV
//   operand_a  in   multiplicand / dividend
//   operand_b  in   multiplier / divisor
//   busy       out  high exactly while iterating
//   done       out  one-cycle completion pulse
//   hi         out  MULT: product upper half; DIV: remainder
//   lo         out  MULT: product lower half; DIV: quotient
//   div_zero   out  (only with MULDIV_DIVZERO_TRAP_EN) DIV by zero trapped
// Configuration macro: MULDIV_DIVZERO_TRAP_EN. When undefined, a divide by
// zero runs the full iteration count and yields lo=all-ones, hi=dividend.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_TRAP_EN
    ,
    output logic             div_zero
`endif
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

`ifdef MULDIV_DIVZERO_TRAP_EN
    logic trap;
    assign trap = (op == OP_DIV) && (operand_b == '0);
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (op_r),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .a      (a_r),
        .b      (b_r),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_r   <= OP_MULT;
            a_r    <= '0;
            b_r    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_r   <= op;
                        a_r    <= operand_a;
                        b_r    <= operand_b;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= (op == OP_DIV) ? operand_a : operand_b;
                        state  <= S_RUN;
`ifdef MULDIV_DIVZERO_TRAP_EN
                        div_zero <= trap;
                        if (trap) begin
                            state <= S_DONE;
                        end
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    // HI/LO are written straight from the final step so
                    // they change only on the DONE-entry edge.
                    if (cnt == LAST_ITER) begin
                        hi    <= nxt_hi;
                        lo    <= nxt_lo;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
